// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_RPORTS = 2;
    localparam int DEF_NUM_WPORTS = 2;
    localparam int DEF_ZERO_REG   = 1;

    // CLEAR sweeps zeros through the array after reset; RUN is normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write port bundle between decode/writeback and the register file.
// Latency: wires only.
// Backpressure: none; ready only qualifies whether writes take effect.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RPORTS = DEF_NUM_RPORTS,
    parameter int NUM_WPORTS = DEF_NUM_WPORTS
);
    logic                             ready;
    logic [NUM_WPORTS-1:0]            wen;
    logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata;
    logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata;

    // Datapath side: issues reads and writes, observes data and ready.
    modport master (
        output wen, waddr, wdata, raddr,
        input  rdata, ready
    );

    // Register file side.
    modport slave (
        input  wen, waddr, wdata, raddr,
        output rdata, ready
    );

endinterface

// File: rtl/reg_file_rport.sv
// One read port: array select, write-first bypass, zero-entry and clear forcing.
// Latency: combinational.
// Backpressure: none.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WPORTS = DEF_NUM_WPORTS,
    parameter int ZERO_REG   = DEF_ZERO_REG
) (
    input  logic [DATA_WIDTH-1:0]            i_mem [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0]            i_raddr,
    input  logic                             i_run,
    input  logic [NUM_WPORTS-1:0]            i_wen,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] i_waddr,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0]            o_rdata
);

    // Stored value, overridden by same-cycle writes; higher port index wins
    // because it is evaluated last. Clear state and the zero entry force 0.
    always_comb begin
        o_rdata = i_mem[i_raddr];
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (i_wen[p] && (i_waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == i_raddr)) begin
                o_rdata = i_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (!i_run) begin
            o_rdata = '0;
        end
        if ((ZERO_REG != 0) && (i_raddr == '0)) begin
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with post-reset clearing sweep and write-first bypass.
// Latency: reads combinational; writes stored at the presenting edge.
// Backpressure: none; writes are dropped while ready is low (clear sweep).
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RPORTS = DEF_NUM_RPORTS,
    parameter int NUM_WPORTS = DEF_NUM_WPORTS,
    parameter int ZERO_REG   = DEF_ZERO_REG
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_run;
    logic [NUM_WPORTS-1:0] w_wen_eff;
    logic [DATA_WIDTH-1:0] w_rdata [NUM_RPORTS];

    assign w_run     = (r_state == RUN);
    assign bus.ready = r_ready;

    // Effective write enables: only in RUN, never to the zero entry, and a
    // lower port loses to a higher port targeting the same address.
    always_comb begin
        w_wen_eff = '0;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            w_wen_eff[p] = bus.wen[p] && w_run &&
                           !((ZERO_REG != 0) && (bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == '0));
        end
        for (int p = 0; p < NUM_WPORTS; p++) begin
            for (int q = p + 1; q < NUM_WPORTS; q++) begin
                if (w_wen_eff[q] &&
                    (bus.waddr[q*ADDR_WIDTH +: ADDR_WIDTH] == bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    w_wen_eff[p] = 1'b0;
                end
            end
        end
    end

    // Control FSM: sweep counter runs through every entry once, then RUN.
    // The counter holds at the terminal count instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_cnt == '1) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zero one entry per cycle while clearing, port writes in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int p = 0; p < NUM_WPORTS; p++) begin
                    if (w_wen_eff[p]) begin
                        r_mem[bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RPORTS; r++) begin : g_rport
        reg_file_rport #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_WPORTS (NUM_WPORTS),
            .ZERO_REG   (ZERO_REG)
        ) u_rport (
            .i_mem   (r_mem),
            .i_raddr (bus.raddr[r*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_run   (w_run),
            .i_wen   (bus.wen),
            .i_waddr (bus.waddr),
            .i_wdata (bus.wdata),
            .o_rdata (w_rdata[r])
        );
    end

    // Pack per-port read data onto the flat bus.
    always_comb begin
        bus.rdata = '0;
        for (int r = 0; r < NUM_RPORTS; r++) begin
            bus.rdata[r*DATA_WIDTH +: DATA_WIDTH] = w_rdata[r];
        end
    end

endmodule
